// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the multi-cycle LEGv8 core: latches the opcode on fetch
// and walks FETCH/DECODE/EXEC/MEM/WB, driving every datapath select and strobe.
module multicycle_control_unit (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [10:0] i_opCode,
  input  logic        i_imemReady,
  input  logic        i_dmemReady,
  input  logic        i_ZERO,
  input  logic        i_halt,
  output logic        o_imemRd,
  output logic        o_irWr,
  output logic        o_pcWr,
  output logic        o_PCSrc,
  output logic        o_reg2Sel,
  output logic        o_rfWr,
  output logic [1:0]  o_SEU,
  output logic        o_ALUSrcB,
  output logic [3:0]  o_ALUOp,
  output logic        o_memRd,
  output logic        o_memWr,
  output logic        o_wrDataSel,
  output logic [2:0]  o_state,
  output logic        o_illegal,
  output logic [31:0] o_retired
);

  localparam int unsigned OPW  = 11;
  localparam int unsigned CNTW = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ORR  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;
  localparam logic [3:0] ALU_LSL  = 4'b1000;
  localparam logic [3:0] ALU_LSR  = 4'b1001;

  localparam logic [1:0] SEU_I  = 2'b00;
  localparam logic [1:0] SEU_D  = 2'b01;
  localparam logic [1:0] SEU_B  = 2'b10;
  localparam logic [1:0] SEU_CB = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    C_BAD  = 3'd0,
    C_R    = 3'd1,
    C_I    = 3'd2,
    C_LDUR = 3'd3,
    C_STUR = 3'd4,
    C_CBZ  = 3'd5,
    C_B    = 3'd6
  } class_e;

  function automatic class_e classify(input logic [OPW-1:0] op);
    class_e c;
    casez (op)
      11'b10001011000, 11'b11001011000, 11'b10001010000,
      11'b10101010000, 11'b11010011011, 11'b11010011010: c = C_R;
      11'b1001000100?, 11'b1101000100?:                  c = C_I;
      11'b11111000010:                                   c = C_LDUR;
      11'b11111000000:                                   c = C_STUR;
      11'b10110100???:                                   c = C_CBZ;
      11'b000101?????:                                   c = C_B;
      default:                                           c = C_BAD;
    endcase
    return c;
  endfunction

  state_e            state_q, state_d;
  logic [OPW-1:0]    opcode_q, opcode_d;
  logic              illegal_q, illegal_d;
  logic [CNTW-1:0]   retired_q;

  class_e            cls_c;
  logic [3:0]        alu_op_c;
  logic              alu_srcb_c;
  logic [1:0]        seu_c;
  logic              reg2sel_c;

  // ALU/immediate controls implied by the latched opcode; used in EXEC and held in WB
  always_comb begin
    cls_c      = classify(opcode_q);
    alu_op_c   = 4'b0000;
    alu_srcb_c = 1'b0;
    seu_c      = 2'b00;
    reg2sel_c  = 1'b0;
    case (cls_c)
      C_R: begin
        casez (opcode_q)
          11'b10001011000: alu_op_c = ALU_ADD;
          11'b11001011000: alu_op_c = ALU_SUB;
          11'b10001010000: alu_op_c = ALU_AND;
          11'b10101010000: alu_op_c = ALU_ORR;
          11'b11010011011: alu_op_c = ALU_LSL;
          11'b11010011010: alu_op_c = ALU_LSR;
          default:         alu_op_c = ALU_ADD;
        endcase
      end
      C_I: begin
        alu_op_c   = opcode_q[9] ? ALU_SUB : ALU_ADD;
        alu_srcb_c = 1'b1;
        seu_c      = SEU_I;
      end
      C_LDUR, C_STUR: begin
        alu_op_c   = ALU_ADD;
        alu_srcb_c = 1'b1;
        seu_c      = SEU_D;
        reg2sel_c  = 1'b1;
      end
      C_CBZ: begin
        alu_op_c  = ALU_PASS;
        seu_c     = SEU_CB;
        reg2sel_c = 1'b1;
      end
      C_B:     seu_c = SEU_B;
      default: ;
    endcase
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    illegal_d   = illegal_q;
    o_imemRd    = 1'b0;
    o_irWr      = 1'b0;
    o_pcWr      = 1'b0;
    o_PCSrc     = 1'b0;
    o_reg2Sel   = 1'b0;
    o_rfWr      = 1'b0;
    o_SEU       = 2'b00;
    o_ALUSrcB   = 1'b0;
    o_ALUOp     = 4'b0000;
    o_memRd     = 1'b0;
    o_memWr     = 1'b0;
    o_wrDataSel = 1'b0;

    case (state_q)
      S_FETCH: begin
        o_imemRd = !i_halt;
        if (i_imemReady && !i_halt) begin
          // no IR load while reset is held, even though the state reads FETCH
          o_irWr   = i_rst_n;
          opcode_d = i_opCode;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: state_d = (cls_c == C_BAD) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        o_ALUOp   = alu_op_c;
        o_ALUSrcB = alu_srcb_c;
        o_SEU     = seu_c;
        o_reg2Sel = reg2sel_c;
        case (cls_c)
          C_R, C_I:       state_d = S_WB;
          C_LDUR, C_STUR: state_d = S_MEM;
          C_CBZ: begin
            o_pcWr  = 1'b1;
            o_PCSrc = i_ZERO;
            state_d = S_FETCH;
          end
          C_B: begin
            o_pcWr  = 1'b1;
            o_PCSrc = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        o_memRd = (cls_c == C_LDUR);
        o_memWr = (cls_c == C_STUR);
        if (cls_c != C_LDUR && cls_c != C_STUR) begin
          state_d = S_FETCH;
        end else if (i_dmemReady) begin
          if (cls_c == C_LDUR) begin
            state_d = S_WB;
          end else begin
            o_pcWr  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        o_ALUOp     = alu_op_c;
        o_ALUSrcB   = alu_srcb_c;
        o_SEU       = seu_c;
        o_reg2Sel   = reg2sel_c;
        o_rfWr      = 1'b1;
        o_pcWr      = 1'b1;
        o_wrDataSel = (cls_c != C_LDUR);
        state_d     = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    if (state_d == S_TRAP) illegal_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
      if (o_pcWr) retired_q <= retired_q + CNTW'(1);
    end
  end

  assign o_state   = 3'(state_q);
  assign o_illegal = illegal_q;
  assign o_retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class
// through its state sequence and compares strobes against hand-derived values.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

  logic        i_clk, i_rst_n;
  logic [10:0] i_opCode;
  logic        i_imemReady, i_dmemReady, i_ZERO, i_halt;
  logic        o_imemRd, o_irWr, o_pcWr, o_PCSrc, o_reg2Sel, o_rfWr;
  logic [1:0]  o_SEU;
  logic        o_ALUSrcB;
  logic [3:0]  o_ALUOp;
  logic        o_memRd, o_memWr, o_wrDataSel;
  logic [2:0]  o_state;
  logic        o_illegal;
  logic [31:0] o_retired;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control_unit dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opCode(i_opCode),
    .i_imemReady(i_imemReady), .i_dmemReady(i_dmemReady),
    .i_ZERO(i_ZERO), .i_halt(i_halt),
    .o_imemRd(o_imemRd), .o_irWr(o_irWr), .o_pcWr(o_pcWr), .o_PCSrc(o_PCSrc),
    .o_reg2Sel(o_reg2Sel), .o_rfWr(o_rfWr), .o_SEU(o_SEU), .o_ALUSrcB(o_ALUSrcB),
    .o_ALUOp(o_ALUOp), .o_memRd(o_memRd), .o_memWr(o_memWr),
    .o_wrDataSel(o_wrDataSel), .o_state(o_state), .o_illegal(o_illegal),
    .o_retired(o_retired)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one clock and land mid-low-phase, away from the rising edge
  task automatic next_cycle();
    @(negedge i_clk);
    #1;
  endtask

  int mem_cycles;
  int total_cycles;

  initial begin
    i_rst_n     = 1'b0;
    i_opCode    = 11'b0;
    i_imemReady = 1'b1;
    i_dmemReady = 1'b1;
    i_ZERO      = 1'b0;
    i_halt      = 1'b0;
    #2;
    check("rst_state",   32'(o_state),   32'd0);
    check("rst_irWr",    32'(o_irWr),    32'd0);
    check("rst_imemRd",  32'(o_imemRd),  32'd1);
    check("rst_illegal", 32'(o_illegal), 32'd0);
    check("rst_retired", o_retired,      32'd0);
    check("rst_pcWr",    32'(o_pcWr),    32'd0);

    // ADD, zero-wait memories
    @(negedge i_clk);
    i_rst_n  = 1'b1;
    i_opCode = 11'b10001011000;
    #1;
    check("add_f_state", 32'(o_state), 32'd0);
    check("add_f_irWr",  32'(o_irWr),  32'd1);
    next_cycle();
    check("add_d_state", 32'(o_state), 32'd1);
    check("add_d_irWr",  32'(o_irWr),  32'd0);
    next_cycle();
    check("add_e_state", 32'(o_state), 32'd2);
    check("add_e_aluop", 32'(o_ALUOp), 32'h2);
    check("add_e_srcb",  32'(o_ALUSrcB), 32'd0);
    check("add_e_pcWr",  32'(o_pcWr),  32'd0);
    next_cycle();
    check("add_w_state", 32'(o_state),     32'd4);
    check("add_w_rfWr",  32'(o_rfWr),      32'd1);
    check("add_w_wds",   32'(o_wrDataSel), 32'd1);
    check("add_w_pcWr",  32'(o_pcWr),      32'd1);
    check("add_w_aluop", 32'(o_ALUOp),     32'h2);
    next_cycle();
    check("add_done_state",   32'(o_state), 32'd0);
    check("add_done_retired", o_retired,    32'd1);

    // LDUR with three wait cycles in MEM
    i_opCode    = 11'b11111000010;
    i_dmemReady = 1'b0;
    total_cycles = 1;
    next_cycle(); total_cycles++;
    check("ldur_d_state", 32'(o_state), 32'd1);
    next_cycle(); total_cycles++;
    check("ldur_e_state", 32'(o_state),   32'd2);
    check("ldur_e_aluop", 32'(o_ALUOp),   32'h2);
    check("ldur_e_srcb",  32'(o_ALUSrcB), 32'd1);
    check("ldur_e_seu",   32'(o_SEU),     32'd1);
    check("ldur_e_r2s",   32'(o_reg2Sel), 32'd1);
    mem_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      next_cycle(); total_cycles++;
      if (i == 3) i_dmemReady = 1'b1;
      check("ldur_m_state", 32'(o_state), 32'd3);
      check("ldur_m_pcWr",  32'(o_pcWr),  32'd0);
      if (o_memRd) mem_cycles++;
    end
    check("ldur_memrd_cycles", 32'(mem_cycles), 32'd4);
    next_cycle(); total_cycles++;
    check("ldur_w_state", 32'(o_state),     32'd4);
    check("ldur_w_wds",   32'(o_wrDataSel), 32'd0);
    check("ldur_w_rfWr",  32'(o_rfWr),      32'd1);
    check("ldur_w_memRd", 32'(o_memRd),     32'd0);
    check("ldur_total_cycles", 32'(total_cycles), 32'd8);
    next_cycle();
    check("ldur_done_state",   32'(o_state), 32'd0);
    check("ldur_done_retired", o_retired,    32'd2);

    // CBZ taken then not taken
    for (int z = 1; z >= 0; z--) begin
      i_opCode = 11'b10110100101;
      i_ZERO   = 1'(z);
      next_cycle();
      next_cycle();
      check("cbz_e_state", 32'(o_state),   32'd2);
      check("cbz_e_aluop", 32'(o_ALUOp),   32'h7);
      check("cbz_e_pcWr",  32'(o_pcWr),    32'd1);
      check("cbz_e_pcsrc", 32'(o_PCSrc),   32'(z));
      check("cbz_e_seu",   32'(o_SEU),     32'd3);
      check("cbz_e_r2s",   32'(o_reg2Sel), 32'd1);
      check("cbz_e_rfWr",  32'(o_rfWr),    32'd0);
      check("cbz_e_mem",   32'({o_memRd, o_memWr}), 32'd0);
      next_cycle();
      check("cbz_done_state", 32'(o_state), 32'd0);
    end
    check("cbz_retired", o_retired, 32'd4);

    // B: unconditional, 3 cycles
    i_opCode = 11'b00010111111;
    next_cycle();
    next_cycle();
    check("b_e_pcsrc", 32'(o_PCSrc), 32'd1);
    check("b_e_seu",   32'(o_SEU),   32'd2);
    check("b_e_pcWr",  32'(o_pcWr),  32'd1);
    next_cycle();
    check("b_done_state", 32'(o_state), 32'd0);

    // SUBI: immediate path, SUB op
    i_opCode = 11'b11010001001;
    next_cycle();
    next_cycle();
    check("subi_e_aluop", 32'(o_ALUOp),   32'h6);
    check("subi_e_srcb",  32'(o_ALUSrcB), 32'd1);
    check("subi_e_seu",   32'(o_SEU),     32'd0);
    next_cycle();
    check("subi_w_state", 32'(o_state), 32'd4);
    check("subi_w_aluop", 32'(o_ALUOp), 32'h6);
    next_cycle();

    // LSR: shift op encoding
    i_opCode = 11'b11010011010;
    next_cycle();
    next_cycle();
    check("lsr_e_aluop", 32'(o_ALUOp), 32'h9);
    next_cycle();
    next_cycle();
    check("lsr_retired", o_retired, 32'd7);

    // halt wins over imemReady in FETCH
    i_opCode = 11'b11111000000;
    i_halt   = 1'b1;
    #1;
    check("halt_imemRd", 32'(o_imemRd), 32'd0);
    check("halt_irWr",   32'(o_irWr),   32'd0);
    next_cycle();
    check("halt_state", 32'(o_state), 32'd0);
    i_halt = 1'b0;
    #1;
    check("unhalt_irWr", 32'(o_irWr), 32'd1);
    next_cycle();
    check("unhalt_state", 32'(o_state), 32'd1);

    // STUR after preloading the retire counter to all ones
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    next_cycle();
    check("stur_e_state", 32'(o_state), 32'd2);
    next_cycle();
    check("stur_m_state", 32'(o_state), 32'd3);
    check("stur_m_memWr", 32'(o_memWr), 32'd1);
    check("stur_m_memRd", 32'(o_memRd), 32'd0);
    check("stur_m_pcWr",  32'(o_pcWr),  32'd1);
    next_cycle();
    check("stur_done_state", 32'(o_state), 32'd0);
    check("stur_wrap",       o_retired,    32'd0);

    // unsupported opcode traps and holds
    i_opCode = 11'b11111111111;
    next_cycle();
    check("trap_d_state", 32'(o_state), 32'd1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check("trap_state",   32'(o_state),   32'd7);
      check("trap_illegal", 32'(o_illegal), 32'd1);
      check("trap_pcWr",    32'(o_pcWr),    32'd0);
      check("trap_imemRd",  32'(o_imemRd),  32'd0);
    end
    check("trap_retired", o_retired, 32'd0);
    i_rst_n = 1'b0;
    #1;
    check("trap_rst_state",   32'(o_state),   32'd0);
    check("trap_rst_illegal", 32'(o_illegal), 32'd0);
    check("trap_rst_irWr",    32'(o_irWr),    32'd0);
    next_cycle();
    i_rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
